// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared constants and hex glyph lookup for the digit scanner
package seg_pkg;

   localparam int         NUM_DIGITS = 6;
   localparam logic [5:0] DIG_OFF    = 6'b111111;
   localparam logic [6:0] SEG_BLANK  = 7'h00;

   // Segment order {g,f,e,d,c,b,a}, active high
   localparam logic [6:0] GLYPH_0 = 7'h3F;
   localparam logic [6:0] GLYPH_1 = 7'h06;
   localparam logic [6:0] GLYPH_2 = 7'h5B;
   localparam logic [6:0] GLYPH_3 = 7'h4F;
   localparam logic [6:0] GLYPH_4 = 7'h66;
   localparam logic [6:0] GLYPH_5 = 7'h6D;
   localparam logic [6:0] GLYPH_6 = 7'h7D;
   localparam logic [6:0] GLYPH_7 = 7'h07;
   localparam logic [6:0] GLYPH_8 = 7'h7F;
   localparam logic [6:0] GLYPH_9 = 7'h6F;
   localparam logic [6:0] GLYPH_A = 7'h77;
   localparam logic [6:0] GLYPH_B = 7'h7C;
   localparam logic [6:0] GLYPH_C = 7'h39;
   localparam logic [6:0] GLYPH_D = 7'h5E;
   localparam logic [6:0] GLYPH_E = 7'h79;
   localparam logic [6:0] GLYPH_F = 7'h71;

   function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
      logic [6:0] glyph;
      glyph = SEG_BLANK;
      case (nibble)
         4'h0: glyph = GLYPH_0;
         4'h1: glyph = GLYPH_1;
         4'h2: glyph = GLYPH_2;
         4'h3: glyph = GLYPH_3;
         4'h4: glyph = GLYPH_4;
         4'h5: glyph = GLYPH_5;
         4'h6: glyph = GLYPH_6;
         4'h7: glyph = GLYPH_7;
         4'h8: glyph = GLYPH_8;
         4'h9: glyph = GLYPH_9;
         4'hA: glyph = GLYPH_A;
         4'hB: glyph = GLYPH_B;
         4'hC: glyph = GLYPH_C;
         4'hD: glyph = GLYPH_D;
         4'hE: glyph = GLYPH_E;
         default: glyph = GLYPH_F;
      endcase
      return glyph;
   endfunction

endpackage

// File: rtl/seg_decode.sv
// rtl/seg_decode.sv - combinational nibble to seven-segment glyph
module seg_decode
   import seg_pkg::*;
(
   input  logic [3:0] nibble_i,
   output logic [6:0] seg_o
);

   assign seg_o = hex_to_seg(nibble_i);

endmodule

// File: rtl/seg_scan_mux.sv
// rtl/seg_scan_mux.sv - 6-digit multiplexed seven-segment scanner with frame-synchronous load
module seg_scan_mux
   import seg_pkg::*;
#(
   parameter int DWELL      = 2,
   parameter int BLANK_GAP  = 1,
   parameter int BLINK_HALF = 500
) (
   input  logic        CLK1K,
   input  logic        nRST,
   input  logic [23:0] digits_in,
   input  logic        load,
   input  logic [5:0]  blink_en,
   input  logic        lzb,
   output logic [6:0]  seg,
   output logic [5:0]  dig,
   output logic        frame_start
);

   localparam int            BW         = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
   localparam logic [7:0]    DWELL_LAST = 8'(DWELL - 1);
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

   logic [23:0]   pending_q, pending_d;
   logic [23:0]   shadow_q, shadow_d;
   logic [2:0]    idx_q, idx_d;
   logic [7:0]    cnt_q, cnt_d;
   logic [BW-1:0] blink_cnt_q, blink_cnt_d;
   logic          blink_off_q, blink_off_d;
   logic [6:0]    seg_q, seg_d;
   logic [5:0]    dig_q, dig_d;
   logic          fs_q, fs_d;

   logic                  dwell_end, frame_end, blink_wrap;
   logic                  gap, suppress, zero_run;
   logic [NUM_DIGITS-1:0] lead_zero;
   logic [3:0]            sel_nib;
   logic [6:0]            sel_seg;

   seg_decode u_decode (
      .nibble_i (sel_nib),
      .seg_o    (sel_seg)
   );

   always_comb begin
      dwell_end   = (cnt_q == DWELL_LAST);
      frame_end   = dwell_end && (idx_q == 3'(NUM_DIGITS - 1));
      blink_wrap  = (blink_cnt_q == BLINK_LAST);

      cnt_d       = dwell_end ? 8'd0 : cnt_q + 8'd1;
      idx_d       = idx_q;
      if (dwell_end) idx_d = frame_end ? 3'd0 : idx_q + 3'd1;
      blink_cnt_d = blink_wrap ? '0 : blink_cnt_q + 1'b1;
      blink_off_d = blink_off_q ^ blink_wrap;

      // A load on the boundary cycle reaches shadow through pending_d
      pending_d   = load ? digits_in : pending_q;
      shadow_d    = frame_end ? pending_d : shadow_q;

      zero_run     = 1'b1;
      lead_zero    = '0;
      for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
         zero_run     = zero_run && (shadow_q[4*i +: 4] == 4'h0);
         lead_zero[i] = zero_run;
      end

      sel_nib  = 4'h0;
      suppress = 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (idx_q == 3'(i)) begin
            sel_nib  = shadow_q[4*i +: 4];
            suppress = (lzb && lead_zero[i]) || (blink_off_q && blink_en[i]);
         end
      end

      gap   = (BLANK_GAP != 0) && (cnt_q == 8'd0);
      dig_d = ~(6'b000001 << idx_q);
      seg_d = suppress ? SEG_BLANK : sel_seg;
      if (gap) begin
         dig_d = DIG_OFF;
         seg_d = SEG_BLANK;
      end
      fs_d  = (idx_q == 3'd0) && (cnt_q == 8'd0);
   end

   always_ff @(posedge CLK1K) begin
      if (!nRST) begin
         pending_q   <= '0;
         shadow_q    <= '0;
         idx_q       <= '0;
         cnt_q       <= '0;
         blink_cnt_q <= '0;
         blink_off_q <= 1'b0;
         seg_q       <= SEG_BLANK;
         dig_q       <= DIG_OFF;
         fs_q        <= 1'b0;
      end else begin
         pending_q   <= pending_d;
         shadow_q    <= shadow_d;
         idx_q       <= idx_d;
         cnt_q       <= cnt_d;
         blink_cnt_q <= blink_cnt_d;
         blink_off_q <= blink_off_d;
         seg_q       <= seg_d;
         dig_q       <= dig_d;
         fs_q        <= fs_d;
      end
   end

   assign seg         = seg_q;
   assign dig         = dig_q;
   assign frame_start = fs_q;

endmodule

// File: tb/tb_seg_scan_mux.sv
// tb/tb_seg_scan_mux.sv - self-checking bench for the seven-segment scanner
module tb_seg_scan_mux;

   logic        clk = 1'b0;
   logic        nrst;
   logic [23:0] digits_in;
   logic        load;
   logic [5:0]  blink_en;
   logic        lzb;
   logic [6:0]  seg;
   logic [5:0]  dig;
   logic        frame_start;

   int total;
   int bad;

   typedef struct {
      logic [23:0] digits;
      logic        lzb;
      logic [41:0] exp;
   } vec_t;

   vec_t tbl[6];
   int   sb_q[$];

   seg_scan_mux #(.DWELL(2), .BLANK_GAP(1), .BLINK_HALF(500)) dut (
      .CLK1K       (clk),
      .nRST        (nrst),
      .digits_in   (digits_in),
      .load        (load),
      .blink_en    (blink_en),
      .lzb         (lzb),
      .seg         (seg),
      .dig         (dig),
      .frame_start (frame_start)
   );

   always #5 clk = ~clk;

   function automatic logic [41:0] pk(input logic [6:0] s5, input logic [6:0] s4, input logic [6:0] s3,
                                      input logic [6:0] s2, input logic [6:0] s1, input logic [6:0] s0);
      return {s5, s4, s3, s2, s1, s0};
   endfunction

   task automatic check_rst(input string tag);
      total++;
      if (seg !== 7'h00 || dig !== 6'h3F || frame_start !== 1'b0) begin
         bad++;
         $display("FAIL %s: got seg=%02h dig=%02h fs=%0b, want seg=00 dig=3F fs=0", tag, seg, dig, frame_start);
      end
   endtask

   // k = position within a 12-cycle frame (DWELL=2, gap on the first cycle of each dwell)
   task automatic check_cycle(input int k, input logic [41:0] exp, input string tag);
      logic [5:0] e_dig;
      logic [6:0] e_seg;
      logic       e_fs;
      int         idx;
      idx = k / 2;
      if (k % 2 == 0) begin
         e_dig = 6'h3F;
         e_seg = 7'h00;
      end else begin
         e_dig = 6'h3F & ~(6'd1 << idx);
         e_seg = exp[idx*7 +: 7];
      end
      e_fs = (k == 0);
      total++;
      if (seg !== e_seg || dig !== e_dig || frame_start !== e_fs) begin
         bad++;
         $display("FAIL %s k=%0d: got seg=%02h dig=%02h fs=%0b, want seg=%02h dig=%02h fs=%0b",
                  tag, k, seg, dig, frame_start, e_seg, e_dig, e_fs);
      end
   endtask

   task automatic frame(input logic [41:0] exp, input string tag,
                        input int ld_k, input logic [23:0] ld_d,
                        input int ld2_k, input logic [23:0] ld2_d);
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         check_cycle(k, exp, tag);
         if (k == ld_k) begin
            digits_in = ld_d;
            load      = 1'b1;
         end else if (k == ld2_k) begin
            digits_in = ld2_d;
            load      = 1'b1;
         end else begin
            load = 1'b0;
         end
      end
   endtask

   initial begin
      logic [41:0] cur;
      logic [41:0] bexp;
      int          vi;

      total     = 0;
      bad       = 0;
      nrst      = 1'b0;
      digits_in = 24'h0;
      load      = 1'b0;
      blink_en  = 6'b000001;
      lzb       = 1'b0;

      tbl[0] = '{24'h000125, 1'b0, pk(7'h3F, 7'h3F, 7'h3F, 7'h06, 7'h5B, 7'h6D)};
      tbl[1] = '{24'h000105, 1'b1, pk(7'h00, 7'h00, 7'h00, 7'h06, 7'h3F, 7'h6D)};
      tbl[2] = '{24'h000000, 1'b1, pk(7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h3F)};
      tbl[3] = '{24'hFEDCBA, 1'b0, pk(7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77)};
      tbl[4] = '{24'h987654, 1'b1, pk(7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D, 7'h66)};
      tbl[5] = '{24'h00F000, 1'b1, pk(7'h00, 7'h00, 7'h71, 7'h3F, 7'h3F, 7'h3F)};

      repeat (20) begin
         @(negedge clk);
         check_rst("reset_hold");
      end
      nrst = 1'b1;

      // Gap/timing pattern plus digit-0 blink over three half-periods
      for (int j = 0; j < 1500; j++) begin
         @(negedge clk);
         bexp = {6{7'h3F}};
         if (j >= 500 && j < 1000) bexp[6:0] = 7'h00;
         check_cycle(j % 12, bexp, "blink_scan");
      end
      blink_en = 6'b000000;

      cur = {6{7'h3F}};
      for (int v = 0; v < 6; v++) begin
         frame(cur, "pre_load_frame", 3, tbl[v].digits, -1, 24'h0);
         sb_q.push_back(v);
         vi  = sb_q.pop_front();
         cur = tbl[vi].exp;
         lzb = tbl[vi].lzb;
      end

      frame(cur, "last_vec_multi", 2, 24'h111111, 6, 24'h222222);
      cur = {6{7'h5B}};
      frame(cur, "last_wins", 10, 24'hFEDCBA, -1, 24'h0);
      cur = tbl[3].exp;
      frame(cur, "coincident_load", -1, 24'h0, -1, 24'h0);
      frame(cur, "coincident_hold", -1, 24'h0, -1, 24'h0);

      lzb = 1'b0;
      repeat (5) @(negedge clk);
      nrst = 1'b0;
      repeat (3) begin
         @(negedge clk);
         check_rst("mid_frame_reset");
      end
      nrst = 1'b1;
      frame({6{7'h3F}}, "post_reset_frame", -1, 24'h0, -1, 24'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
